// File: rtl/uart_rx_byte_fifo_if.sv
// Bundles the receiver-facing capture signals, the FWFT read handshake and
// the status/statistics outputs of uart_rx_byte_fifo.
interface uart_rx_byte_fifo_if #(
  parameter int ADDR_W = 3
);
  // capture side (from the UART receiver)
  logic [7:0]    Data_Rx;
  logic          Rdsig;
  logic          DataError_Flag;
  logic          FrameError_Flag;
  // read side (host / protocol logic)
  logic          Rd_En;
  logic [7:0]    Rd_Data;
  logic          Rd_ParErr;
  logic          Rd_FrmErr;
  logic          Rd_Valid;
  // status
  logic          Full;
  logic [ADDR_W:0] Count;
  logic          Overflow;
  logic          Clr_Ovf;
  logic [7:0]    Err_Cnt;

  // the FIFO itself
  modport slave (
    input  Data_Rx, Rdsig, DataError_Flag, FrameError_Flag, Rd_En, Clr_Ovf,
    output Rd_Data, Rd_ParErr, Rd_FrmErr, Rd_Valid, Full, Count, Overflow, Err_Cnt
  );

  // whoever drives the receiver signals and reads the FIFO
  modport master (
    output Data_Rx, Rdsig, DataError_Flag, FrameError_Flag, Rd_En, Clr_Ovf,
    input  Rd_Data, Rd_ParErr, Rd_FrmErr, Rd_Valid, Full, Count, Overflow, Err_Cnt
  );
endinterface

// File: rtl/uart_rx_byte_fifo.sv
// Receive-side byte FIFO behind the UART receiver. A falling edge of Rdsig
// marks the end of a frame; the byte and its parity/framing tags are pushed
// into a first-word-fall-through FIFO. A sticky overflow flag records frames
// lost to a full FIFO, and a saturating counter tallies frames with errors.
module uart_rx_byte_fifo #(
  parameter int ADDR_W   = 3,
  parameter bit DROP_ERR = 1'b0
) (
  input  logic              CLK,
  input  logic              RST,
  uart_rx_byte_fifo_if.slave bus
);
  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W:0] FULL_CNT = {1'b1, {ADDR_W{1'b0}}};

  // entry layout: {frame_err, parity_err, data[7:0]}
  logic [9:0]        mem_q [DEPTH];
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              ovf_q, ovf_d;
  logic [7:0]        err_cnt_q, err_cnt_d;
  logic              rdsig_q;

  logic              push_req, frame_bad, store_req;
  logic              full, not_empty, do_pop, do_write;
  logic [9:0]        head;

  // one-cycle end-of-frame strobe; both error flags are settled here
  assign push_req  = rdsig_q & ~bus.Rdsig;
  assign frame_bad = bus.DataError_Flag | bus.FrameError_Flag;
  assign store_req = push_req & ~(DROP_ERR & frame_bad);

  assign full      = (count_q == FULL_CNT);
  assign not_empty = (count_q != '0);
  // pop is qualified by the pre-edge valid, so a push into an empty FIFO
  // cannot be popped in the same cycle
  assign do_pop    = bus.Rd_En & not_empty;
  // a full FIFO still accepts a write when a pop frees a slot in the same cycle
  assign do_write  = store_req & (~full | do_pop);

  // next-state for pointers, occupancy and statistics
  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    ovf_d     = ovf_q;
    err_cnt_d = err_cnt_q;

    if (do_write) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)   rd_ptr_d = rd_ptr_q + 1'b1;

    if (do_write && !do_pop)      count_d = count_q + 1'b1;
    else if (!do_write && do_pop) count_d = count_q - 1'b1;

    // a new loss wins over a simultaneous clear
    if (store_req && full && !do_pop) ovf_d = 1'b1;
    else if (bus.Clr_Ovf)             ovf_d = 1'b0;

    if (push_req && frame_bad && err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 1'b1;
  end

  // control/status registers, synchronous reset
  always_ff @(posedge CLK) begin
    if (RST) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      ovf_q     <= 1'b0;
      err_cnt_q <= '0;
      rdsig_q   <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      ovf_q     <= ovf_d;
      err_cnt_q <= err_cnt_d;
      rdsig_q   <= bus.Rdsig;
    end
  end

  // storage array; contents are not reset
  always_ff @(posedge CLK) begin
    if (!RST && do_write)
      mem_q[wr_ptr_q] <= {bus.FrameError_Flag, bus.DataError_Flag, bus.Data_Rx};
  end

  // head entry falls through; forced to zero while empty so stale or
  // uninitialised RAM never appears on the outputs
  assign head          = not_empty ? mem_q[rd_ptr_q] : 10'd0;
  assign bus.Rd_Data   = head[7:0];
  assign bus.Rd_ParErr = head[8];
  assign bus.Rd_FrmErr = head[9];
  assign bus.Rd_Valid  = not_empty;
  assign bus.Full      = full;
  assign bus.Count     = count_q;
  assign bus.Overflow  = ovf_q;
  assign bus.Err_Cnt   = err_cnt_q;
endmodule

// File: tb/tb_uart_rx_byte_fifo.sv
// Bench for uart_rx_byte_fifo: two instances (DROP_ERR=0 and 1) share one
// stimulus stream. Each has a queue-based reference model; a negedge monitor
// compares status and the head entry against it.
module tb_uart_rx_byte_fifo;
  localparam int AW    = 3;
  localparam int DEPTH = 1 << AW;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rdsig = 1'b0, pe = 1'b0, fe = 1'b0, rd_en = 1'b0, clr = 1'b0;
  logic [7:0] data_rx = 8'h00;

  int checks   = 0;
  int failures = 0;
  bit started  = 1'b0;

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int g, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s[drop=%0d] got=%0h exp=%0h @%0t", nm, g, act, exp, $time);
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : g_inst
    uart_rx_byte_fifo_if #(.ADDR_W(AW)) bus ();

    assign bus.Data_Rx         = data_rx;
    assign bus.Rdsig           = rdsig;
    assign bus.DataError_Flag  = pe;
    assign bus.FrameError_Flag = fe;
    assign bus.Rd_En           = rd_en;
    assign bus.Clr_Ovf         = clr;

    uart_rx_byte_fifo #(.ADDR_W(AW), .DROP_ERR(g)) dut (
      .CLK(clk),
      .RST(rst),
      .bus(bus)
    );

    // reference model: expected contents as a queue of {frm,par,data}
    logic [9:0] mq[$];
    int  ovf = 0, ec = 0;
    bit  prv = 1'b0;
    bit  m_push, m_err, m_pop, m_store;
    int  n;

    always @(posedge clk) begin
      if (rst) begin
        mq.delete();
        ovf = 0; ec = 0; prv = 1'b0;
      end else begin
        m_push  = prv && !rdsig;
        m_err   = pe || fe;
        n       = mq.size();
        m_pop   = rd_en && (n > 0);
        m_store = m_push && !(g == 1 && m_err);
        if (m_push && m_err && ec < 255) ec++;
        if (m_pop) void'(mq.pop_front());
        if (m_store && (n < DEPTH || m_pop)) mq.push_back({fe, pe, data_rx});
        if (m_store && n == DEPTH && !m_pop) ovf = 1;
        else if (clr) ovf = 0;
        prv = rdsig;
      end
    end

    // monitor: status every cycle, head entry whenever the DUT presents one
    always @(negedge clk) begin
      if (started) begin
        chk("count",  g, 32'(bus.Count),    mq.size());
        chk("full",   g, 32'(bus.Full),     32'(mq.size() == DEPTH));
        chk("valid",  g, 32'(bus.Rd_Valid), 32'(mq.size() != 0));
        chk("ovf",    g, 32'(bus.Overflow), ovf);
        chk("errcnt", g, 32'(bus.Err_Cnt),  ec);
        if (mq.size() != 0)
          chk("head", g, 32'({bus.Rd_FrmErr, bus.Rd_ParErr, bus.Rd_Data}), 32'(mq[0]));
        else
          chk("head_empty", g, 32'({bus.Rd_FrmErr, bus.Rd_ParErr, bus.Rd_Data}), 32'd0);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Rdsig high for 'hold' cycles, then falls; returns after the push edge
  task automatic frame(input logic [7:0] d, input logic p, input logic f, input int hold);
    data_rx = d; pe = p; fe = f; rdsig = 1'b1;
    repeat (hold) tick();
    rdsig = 1'b0;
    tick();
    pe = 1'b0; fe = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    tick();
    started = 1'b1;
    tick();
    rst = 1'b0;
    tick();

    // single frame, then drain
    frame(8'hA5, 1'b0, 1'b0, 2);
    tick();
    rd_en = 1'b1; tick(); rd_en = 1'b0; tick();

    // fill to full, overflow on the ninth, read three (Count=5, Overflow=1), reset
    for (int i = 0; i < 9; i++) frame(8'(i), 1'b0, 1'b0, 1);
    tick();
    rd_en = 1'b1; repeat (3) tick(); rd_en = 1'b0;
    tick();
    rst = 1'b1; tick(); rst = 1'b0; tick();

    // full FIFO, push 0x55 together with a pop, then drain everything
    for (int i = 0; i < 8; i++) frame(8'h10 + 8'(i), 1'b0, 1'b0, 1);
    data_rx = 8'h55; rdsig = 1'b1; tick();
    rd_en = 1'b1; rdsig = 1'b0; tick();
    repeat (9) tick();
    rd_en = 1'b0;

    // overflow, then clear colliding with a fresh overflow, then plain clear
    for (int i = 0; i < 9; i++) frame(8'h20 + 8'(i), 1'b0, 1'b0, 1);
    data_rx = 8'h99; rdsig = 1'b1; tick();
    rdsig = 1'b0; clr = 1'b1; tick();
    clr = 1'b0; tick();
    clr = 1'b1; tick(); clr = 1'b0;
    rd_en = 1'b1; repeat (9) tick(); rd_en = 1'b0;

    // error-tagged frames (kept by one instance, dropped by the other)
    frame(8'h3C, 1'b1, 1'b0, 1);
    frame(8'h3C, 1'b0, 1'b1, 1);
    frame(8'hC3, 1'b1, 1'b1, 2);
    tick();
    rd_en = 1'b1; repeat (3) tick(); rd_en = 1'b0;

    // Rd_En held on an empty FIFO while a frame arrives
    rd_en = 1'b1;
    frame(8'h77, 1'b0, 1'b0, 2);
    tick(); tick();
    rd_en = 1'b0;

    // Rdsig high across reset must not create a push after release
    rdsig = 1'b1; rst = 1'b1; tick();
    rst = 1'b0; rdsig = 1'b0; tick(); tick();

    // Err_Cnt saturation
    rd_en = 1'b1;
    for (int i = 0; i < 260; i++) frame(8'(i), 1'b1, 1'b0, 1);
    rd_en = 1'b0;
    tick();

    // randomized traffic, alternating fill-biased and drain-biased phases
    rst = 1'b1; tick(); rst = 1'b0;
    for (int c = 0; c < 4000; c++) begin
      rdsig   = 1'($urandom_range(0, 1));
      data_rx = 8'($urandom);
      pe      = ($urandom_range(0, 7) == 0);
      fe      = ($urandom_range(0, 7) == 0);
      rd_en   = ((c / 500) % 2 == 0) ? ($urandom_range(0, 9) < 2) : ($urandom_range(0, 9) < 7);
      clr     = ($urandom_range(0, 31) == 0);
      rst     = ($urandom_range(0, 699) == 0);
      tick();
    end
    rst = 1'b0; rdsig = 1'b0; rd_en = 1'b0; clr = 1'b0; pe = 1'b0; fe = 1'b0;
    tick(); tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
